// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: initiator for a single-port 64-bit line RAM.
// The RAM uses active-low ceb/web/bweb and has a 1-cycle registered read.
// Byte-addressed 1/2/4/8-byte loads and stores arrive from the core over valid/ready.
// An access that straddles a 64-bit line is split into two RAM cycles.
// The core gets exactly one response pulse per request.
module ram_port_ctrl #(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [31:0]       req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [63:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [63:0]       rsp_rdata_o,
  output logic              mem_ceb_o,
  output logic              mem_web_o,
  output logic [63:0]       mem_bweb_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [63:0]       mem_wdata_o,
  input  logic [63:0]       mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAP, RESP} state_t;

  localparam logic [MEM_AW-1:0] LINE_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

  state_t state_q, state_d;

  // Request fields held for the duration of the access
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [2:0]        off_q;
  logic              cross_q;
  logic [MEM_AW-1:0] line_q;
  logic [63:0]       whi_q;
  logic [63:0]       mhi_q;
  logic [63:0]       line0_q;

  // Decode of the incoming request
  logic [MEM_AW-1:0] dec_line;
  logic [2:0]        dec_off;
  logic [3:0]        dec_n;
  logic              dec_cross;
  logic [63:0]       dec_dmask;
  logic [7:0]        dec_bm8;
  logic [15:0]       dec_bm;
  logic [127:0]      dec_w128;
  logic [127:0]      dec_m128;
  logic              unused_addr_bits;

  // Load extraction
  logic [127:0]      ld_r128;
  logic [63:0]       ld_low;
  logic [63:0]       ld_result;

  // Next values for the registered outputs
  logic              ceb_d;
  logic              web_d;
  logic [63:0]       bweb_d;
  logic [MEM_AW-1:0] addr_d;
  logic [63:0]       wdata_d;
  logic              rsp_valid_d;
  logic [63:0]       rsp_rdata_d;

  assign req_ready_o      = (state_q == IDLE);
  assign unused_addr_bits = ^req_addr_i[31:MEM_AW+3];

  // Decode line, offset, size masks and the 128-bit aligned store image
  always_comb begin
    dec_line  = req_addr_i[MEM_AW+2:3];
    dec_off   = req_addr_i[2:0];
    dec_n     = 4'd1 << req_size_i;
    dec_cross = ({1'b0, dec_off} + dec_n) > 4'd8;
    dec_dmask = '0;
    dec_bm8   = '0;
    case (req_size_i)
      2'd0: begin dec_dmask = 64'h0000_0000_0000_00FF; dec_bm8 = 8'h01; end
      2'd1: begin dec_dmask = 64'h0000_0000_0000_FFFF; dec_bm8 = 8'h03; end
      2'd2: begin dec_dmask = 64'h0000_0000_FFFF_FFFF; dec_bm8 = 8'h0F; end
      default: begin dec_dmask = '1; dec_bm8 = 8'hFF; end
    endcase
    dec_w128 = {64'h0, req_wdata_i & dec_dmask} << {dec_off, 3'b000};
    dec_bm   = {8'h00, dec_bm8} << dec_off;
    dec_m128 = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      dec_m128[8*i +: 8] = {8{dec_bm[i]}};
    end
  end

  // Merge captured line(s), shift down to the offset, then size-extend
  always_comb begin
    ld_r128 = cross_q ? {mem_rdata_i, line0_q} : {64'h0, mem_rdata_i};
    ld_low  = 64'(ld_r128 >> {off_q, 3'b000});
    case (size_q)
      2'd0:    ld_result = {{56{~uns_q & ld_low[7]}},  ld_low[7:0]};
      2'd1:    ld_result = {{48{~uns_q & ld_low[15]}}, ld_low[15:0]};
      2'd2:    ld_result = {{32{~uns_q & ld_low[31]}}, ld_low[31:0]};
      default: ld_result = ld_low;
    endcase
  end

  // Next state and next registered output values
  // Outputs are computed from the transition, so they are valid in the state they belong to
  always_comb begin
    state_d     = state_q;
    ceb_d       = 1'b1;
    web_d       = 1'b1;
    bweb_d      = '1;
    addr_d      = '0;
    wdata_d     = '0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = ACC0;
          ceb_d   = 1'b0;
          addr_d  = dec_line;
          if (req_we_i) begin
            web_d   = 1'b0;
            wdata_d = dec_w128[63:0];
            bweb_d  = ~dec_m128[63:0];
          end
        end
      end
      ACC0: begin
        if (cross_q) begin
          state_d = ACC1;
          ceb_d   = 1'b0;
          addr_d  = line_q + LINE_ONE;
          if (we_q) begin
            web_d   = 1'b0;
            wdata_d = whi_q;
            bweb_d  = ~mhi_q;
          end
        end else if (we_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = CAP;
        end
      end
      ACC1: begin
        if (we_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = CAP;
        end
      end
      CAP: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ld_result;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered RAM/response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_ceb_o   <= 1'b1;
      mem_web_o   <= 1'b1;
      mem_bweb_o  <= '1;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      state_q     <= state_d;
      mem_ceb_o   <= ceb_d;
      mem_web_o   <= web_d;
      mem_bweb_o  <= bweb_d;
      mem_addr_o  <= addr_d;
      mem_wdata_o <= wdata_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_rdata_o <= rsp_rdata_d;
    end
  end

  // Capture request fields at accept; first line of a split load during ACC1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      cross_q <= 1'b0;
      line_q  <= '0;
      whi_q   <= '0;
      mhi_q   <= '0;
      line0_q <= '0;
    end else begin
      if (state_q == IDLE && req_valid_i) begin
        we_q    <= req_we_i;
        uns_q   <= req_unsigned_i;
        size_q  <= req_size_i;
        off_q   <= dec_off;
        cross_q <= dec_cross;
        line_q  <= dec_line;
        whi_q   <= dec_w128[127:64];
        mhi_q   <= dec_m128[127:64];
      end
      if (state_q == ACC1) begin
        line0_q <= mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Directed testbench for ram_port_ctrl with a behavioural line RAM.
module tb_ram_port_ctrl;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [31:0]   req_addr_i;
  logic [1:0]    req_size_i;
  logic          req_unsigned_i;
  logic [63:0]   req_wdata_i;
  logic          rsp_valid_o;
  logic [63:0]   rsp_rdata_o;
  logic          mem_ceb_o;
  logic          mem_web_o;
  logic [63:0]   mem_bweb_o;
  logic [AW-1:0] mem_addr_o;
  logic [63:0]   mem_wdata_o;
  logic [63:0]   mem_rdata_i;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [63:0]   ram [0:(1<<AW)-1];
  logic          ram_clr;

  int            acc_n, rsp_cyc, rsp_cnt;
  logic [AW-1:0] acc_addr [0:1];
  logic          acc_web [0:1];
  logic [63:0]   acc_bweb [0:1];
  logic [63:0]   acc_wdata [0:1];
  logic [63:0]   rsp_data;
  logic          rdy_at [1:8];

  ram_port_ctrl #(.MEM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .mem_ceb_o(mem_ceb_o), .mem_web_o(mem_web_o), .mem_bweb_o(mem_bweb_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Line RAM: bit-masked write, registered read
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= '0;
    end else if (!mem_ceb_o) begin
      if (!mem_web_o)
        ram[mem_addr_o] <= (ram[mem_addr_o] & mem_bweb_o) | (mem_wdata_o & ~mem_bweb_o);
      else
        mem_rdata_i <= ram[mem_addr_o];
    end
  end

  // Issue one request, scramble inputs after accept, record 8 cycles of activity
  task automatic run_req(input logic we, input logic [31:0] a, input logic [1:0] sz,
                         input logic uns, input logic [63:0] wd);
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = a;
    req_size_i = sz; req_unsigned_i = uns; req_wdata_i = wd;
    @(posedge clk); #1;
    req_valid_i = 1'b0; req_we_i = ~we; req_addr_i = ~a;
    req_size_i = ~sz; req_unsigned_i = ~uns; req_wdata_i = ~wd;
    acc_n = 0; rsp_cyc = 0; rsp_cnt = 0; rsp_data = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      rdy_at[k] = req_ready_o;
      if (!mem_ceb_o) begin
        if (acc_n < 2) begin
          acc_addr[acc_n] = mem_addr_o; acc_web[acc_n] = mem_web_o;
          acc_bweb[acc_n] = mem_bweb_o; acc_wdata[acc_n] = mem_wdata_o;
        end
        acc_n++;
      end
      if (rsp_valid_o) begin
        rsp_cnt++;
        if (rsp_cyc == 0) begin rsp_cyc = k; rsp_data = rsp_rdata_o; end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ram_clr = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0;
    req_addr_i = '0; req_size_i = '0; req_unsigned_i = 1'b0; req_wdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (mem_ceb_o !== 1'b1) $display("FAIL rst_ceb got %b exp 1", mem_ceb_o); else pass_cnt++;
    total_cnt++; if (mem_web_o !== 1'b1) $display("FAIL rst_web got %b exp 1", mem_web_o); else pass_cnt++;
    total_cnt++; if (mem_bweb_o !== '1) $display("FAIL rst_bweb got %h exp all ones", mem_bweb_o); else pass_cnt++;
    total_cnt++; if (mem_addr_o !== '0) $display("FAIL rst_addr got %h exp 0", mem_addr_o); else pass_cnt++;
    total_cnt++; if (mem_wdata_o !== '0) $display("FAIL rst_wdata got %h exp 0", mem_wdata_o); else pass_cnt++;
    total_cnt++; if (rsp_valid_o !== 1'b0) $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid_o); else pass_cnt++;
    total_cnt++; if (rsp_rdata_o !== '0) $display("FAIL rst_rsp_rdata got %h exp 0", rsp_rdata_o); else pass_cnt++;
    total_cnt++; if (req_ready_o !== 1'b1) $display("FAIL rst_ready got %b exp 1", req_ready_o); else pass_cnt++;
    rst = 1'b0; ram_clr = 1'b0;
  endtask

  task automatic test_store_dword();
    run_req(1'b1, 32'h10, 2'd3, 1'b0, 64'h1122334455667788);
    total_cnt++; if (acc_n !== 1) $display("FAIL sd_acc_n got %0d exp 1", acc_n); else pass_cnt++;
    total_cnt++; if (acc_addr[0] !== 10'd2) $display("FAIL sd_addr got %h exp 2", acc_addr[0]); else pass_cnt++;
    total_cnt++; if (acc_web[0] !== 1'b0) $display("FAIL sd_web got %b exp 0", acc_web[0]); else pass_cnt++;
    total_cnt++; if (acc_bweb[0] !== 64'h0) $display("FAIL sd_bweb got %h exp 0", acc_bweb[0]); else pass_cnt++;
    total_cnt++; if (acc_wdata[0] !== 64'h1122334455667788) $display("FAIL sd_wdata got %h exp 1122334455667788", acc_wdata[0]); else pass_cnt++;
    total_cnt++; if (rsp_cyc !== 2) $display("FAIL sd_latency got %0d exp 2", rsp_cyc); else pass_cnt++;
    total_cnt++; if (rsp_cnt !== 1) $display("FAIL sd_rsp_count got %0d exp 1", rsp_cnt); else pass_cnt++;
    total_cnt++; if (rsp_data !== 64'h0) $display("FAIL sd_rsp_rdata got %h exp 0", rsp_data); else pass_cnt++;
    total_cnt++; if (ram[2] !== 64'h1122334455667788) $display("FAIL sd_ram2 got %h exp 1122334455667788", ram[2]); else pass_cnt++;
  endtask

  task automatic test_store_byte();
    run_req(1'b1, 32'h0D, 2'd0, 1'b0, 64'h123456789ABCDEAB);
    total_cnt++; if (acc_n !== 1) $display("FAIL sb_acc_n got %0d exp 1", acc_n); else pass_cnt++;
    total_cnt++; if (acc_addr[0] !== 10'd1) $display("FAIL sb_addr got %h exp 1", acc_addr[0]); else pass_cnt++;
    total_cnt++; if (acc_bweb[0] !== 64'hFFFF00FFFFFFFFFF) $display("FAIL sb_bweb got %h exp ffff00ffffffffff", acc_bweb[0]); else pass_cnt++;
    total_cnt++; if (acc_wdata[0] !== 64'h0000AB0000000000) $display("FAIL sb_wdata got %h exp 0000ab0000000000", acc_wdata[0]); else pass_cnt++;
    total_cnt++; if (rsp_cyc !== 2) $display("FAIL sb_latency got %0d exp 2", rsp_cyc); else pass_cnt++;
    total_cnt++; if (rdy_at[1] !== 1'b0) $display("FAIL sb_ready_acc0 got %b exp 0", rdy_at[1]); else pass_cnt++;
    total_cnt++; if (rdy_at[2] !== 1'b0) $display("FAIL sb_ready_resp got %b exp 0", rdy_at[2]); else pass_cnt++;
    total_cnt++; if (rdy_at[3] !== 1'b1) $display("FAIL sb_ready_idle got %b exp 1", rdy_at[3]); else pass_cnt++;
    total_cnt++; if (ram[1] !== 64'h0000AB0000000000) $display("FAIL sb_ram1 got %h exp 0000ab0000000000", ram[1]); else pass_cnt++;
  endtask

  task automatic test_load_half();
    run_req(1'b1, 32'h0, 2'd3, 1'b0, 64'h8001223344556677);
    run_req(1'b0, 32'h06, 2'd1, 1'b0, 64'h0);
    total_cnt++; if (acc_addr[0] !== 10'd0) $display("FAIL lh_addr got %h exp 0", acc_addr[0]); else pass_cnt++;
    total_cnt++; if (acc_web[0] !== 1'b1) $display("FAIL lh_web got %b exp 1", acc_web[0]); else pass_cnt++;
    total_cnt++; if (rsp_cyc !== 3) $display("FAIL lh_latency got %0d exp 3", rsp_cyc); else pass_cnt++;
    total_cnt++; if (rsp_data !== 64'hFFFFFFFFFFFF8001) $display("FAIL lh_signed got %h exp ffffffffffff8001", rsp_data); else pass_cnt++;
    run_req(1'b0, 32'h06, 2'd1, 1'b1, 64'h0);
    total_cnt++; if (rsp_data !== 64'h0000000000008001) $display("FAIL lh_unsigned got %h exp 8001", rsp_data); else pass_cnt++;
    total_cnt++; if (rsp_cnt !== 1) $display("FAIL lh_rsp_count got %0d exp 1", rsp_cnt); else pass_cnt++;
  endtask

  task automatic test_store_cross();
    run_req(1'b1, 32'h0E, 2'd2, 1'b0, 64'hFFFFFFFFDEADBEEF);
    total_cnt++; if (acc_n !== 2) $display("FAIL sc_acc_n got %0d exp 2", acc_n); else pass_cnt++;
    total_cnt++; if (acc_addr[0] !== 10'd1) $display("FAIL sc_addr0 got %h exp 1", acc_addr[0]); else pass_cnt++;
    total_cnt++; if (acc_bweb[0] !== 64'h0000FFFFFFFFFFFF) $display("FAIL sc_bweb0 got %h exp 0000ffffffffffff", acc_bweb[0]); else pass_cnt++;
    total_cnt++; if (acc_wdata[0] !== 64'hBEEF000000000000) $display("FAIL sc_wdata0 got %h exp beef000000000000", acc_wdata[0]); else pass_cnt++;
    total_cnt++; if (acc_addr[1] !== 10'd2) $display("FAIL sc_addr1 got %h exp 2", acc_addr[1]); else pass_cnt++;
    total_cnt++; if (acc_web[1] !== 1'b0) $display("FAIL sc_web1 got %b exp 0", acc_web[1]); else pass_cnt++;
    total_cnt++; if (acc_bweb[1] !== 64'hFFFFFFFFFFFF0000) $display("FAIL sc_bweb1 got %h exp ffffffffffff0000", acc_bweb[1]); else pass_cnt++;
    total_cnt++; if (acc_wdata[1] !== 64'h000000000000DEAD) $display("FAIL sc_wdata1 got %h exp dead", acc_wdata[1]); else pass_cnt++;
    total_cnt++; if (rsp_cyc !== 3) $display("FAIL sc_latency got %0d exp 3", rsp_cyc); else pass_cnt++;
    total_cnt++; if (ram[1] !== 64'hBEEFAB0000000000) $display("FAIL sc_ram1 got %h exp beefab0000000000", ram[1]); else pass_cnt++;
    total_cnt++; if (ram[2] !== 64'h112233445566DEAD) $display("FAIL sc_ram2 got %h exp 112233445566dead", ram[2]); else pass_cnt++;
  endtask

  task automatic test_load_cross();
    run_req(1'b0, 32'h0E, 2'd2, 1'b0, 64'h0);
    total_cnt++; if (rsp_cyc !== 4) $display("FAIL lc_latency got %0d exp 4", rsp_cyc); else pass_cnt++;
    total_cnt++; if (rsp_data !== 64'hFFFFFFFFDEADBEEF) $display("FAIL lc_signed got %h exp ffffffffdeadbeef", rsp_data); else pass_cnt++;
    run_req(1'b0, 32'h0E, 2'd2, 1'b1, 64'h0);
    total_cnt++; if (rsp_data !== 64'h00000000DEADBEEF) $display("FAIL lc_unsigned got %h exp deadbeef", rsp_data); else pass_cnt++;
    run_req(1'b0, 32'h0D, 2'd0, 1'b0, 64'h0);
    total_cnt++; if (rsp_data !== 64'hFFFFFFFFFFFFFFAB) $display("FAIL lb_signed got %h exp ffffffffffffffab", rsp_data); else pass_cnt++;
    total_cnt++; if (rsp_cyc !== 3) $display("FAIL lb_latency got %0d exp 3", rsp_cyc); else pass_cnt++;
  endtask

  task automatic test_top_wrap();
    run_req(1'b1, 32'h1FF8, 2'd3, 1'b0, 64'hA1A2A3A4B1B2B3B4);
    run_req(1'b0, 32'hFFFFFFFC, 2'd3, 1'b0, 64'h0);
    total_cnt++; if (acc_n !== 2) $display("FAIL tw_acc_n got %0d exp 2", acc_n); else pass_cnt++;
    total_cnt++; if (acc_addr[0] !== 10'd1023) $display("FAIL tw_addr0 got %h exp 3ff", acc_addr[0]); else pass_cnt++;
    total_cnt++; if (acc_addr[1] !== 10'd0) $display("FAIL tw_addr1 got %h exp 0", acc_addr[1]); else pass_cnt++;
    total_cnt++; if (rsp_cyc !== 4) $display("FAIL tw_latency got %0d exp 4", rsp_cyc); else pass_cnt++;
    total_cnt++; if (rsp_data !== 64'h44556677A1A2A3A4) $display("FAIL tw_rdata got %h exp 44556677a1a2a3a4", rsp_data); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [6:1] ceb_v, rsp_v, rdy_v;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h30;
    req_size_i = 2'd0; req_unsigned_i = 1'b0; req_wdata_i = 64'h5A;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      ceb_v[k] = mem_ceb_o; rsp_v[k] = rsp_valid_o; rdy_v[k] = req_ready_o;
      if (k == 3) begin @(posedge clk); #1; req_valid_i = 1'b0; end
    end
    total_cnt++; if (ceb_v !== 6'b110110) $display("FAIL bb_ceb got %b exp 110110", ceb_v); else pass_cnt++;
    total_cnt++; if (rsp_v !== 6'b010010) $display("FAIL bb_rsp got %b exp 010010", rsp_v); else pass_cnt++;
    total_cnt++; if (rdy_v !== 6'b100100) $display("FAIL bb_ready got %b exp 100100", rdy_v); else pass_cnt++;
    total_cnt++; if (ram[6] !== 64'h5A) $display("FAIL bb_ram6 got %h exp 5a", ram[6]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int rsp_seen;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h24;
    req_size_i = 2'd3; req_unsigned_i = 1'b0; req_wdata_i = 64'h0102030405060708;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(negedge clk);
    total_cnt++; if (mem_ceb_o !== 1'b0 || mem_addr_o !== 10'd4) $display("FAIL rm_acc0 got ceb %b addr %h exp ceb 0 addr 4", mem_ceb_o, mem_addr_o); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (mem_ceb_o !== 1'b0 || mem_addr_o !== 10'd5) $display("FAIL rm_acc1 got ceb %b addr %h exp ceb 0 addr 5", mem_ceb_o, mem_addr_o); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (mem_ceb_o !== 1'b1) $display("FAIL rm_ceb got %b exp 1", mem_ceb_o); else pass_cnt++;
    total_cnt++; if (mem_web_o !== 1'b1 || mem_bweb_o !== '1) $display("FAIL rm_web_bweb got %b %h exp 1 all ones", mem_web_o, mem_bweb_o); else pass_cnt++;
    total_cnt++; if (req_ready_o !== 1'b1) $display("FAIL rm_ready got %b exp 1", req_ready_o); else pass_cnt++;
    rsp_seen = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid_o) rsp_seen++;
    end
    total_cnt++; if (rsp_seen !== 0) $display("FAIL rm_no_rsp got %0d exp 0", rsp_seen); else pass_cnt++;
    total_cnt++; if (ram[4] !== 64'h0506070800000000) $display("FAIL rm_ram4 got %h exp 0506070800000000", ram[4]); else pass_cnt++;
    total_cnt++; if (ram[5] !== 64'h0) $display("FAIL rm_ram5 got %h exp 0", ram[5]); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_store_dword();
    test_store_byte();
    test_load_half();
    test_store_cross();
    test_load_cross();
    test_top_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
